iterative_divider: RTL and testbench

ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 29 ++
 rtl/iterative_divider.sv | 125 ++++++++++++
 tb/tb_iterative_divider.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing constants for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    // Default operand/result width of the divider.
    localparam int DIV_WIDTH = 64;

    // Iteration counter width: must be able to hold the value DIV_WIDTH itself.
    localparam int CNT_W = $clog2(DIV_WIDTH + 1);

    // Control states: waiting for a request, iterating, presenting the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, commit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_dat,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Shift the partial remainder left, pull in the next dividend bit and try the subtract.
    // When the shifted value already has its top bit set it exceeds any WIDTH-bit divisor,
    // so the commit is forced; otherwise trial[WIDTH] is the borrow of the subtract.
    always_comb begin
        shifted = {rem_dat, dvd_msb};
        trial   = shifted - {1'b0, divisor};
        q_bit   = shifted[WIDTH] | ~trial[WIDTH];
        rem_nxt = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/iterative_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: accept edge E0, WIDTH iteration edges, valid_out for one cycle after edge E(WIDTH).
// Backpressure: none; valid_in is only sampled in IDLE, the requester stalls until valid_out.
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid_out,
    output logic             busy
);

    // Counter is sized to hold WIDTH itself (CNT_W for the default width).
    localparam int CNT_BITS = $clog2(WIDTH + 1);
    // Counter value on the edge that performs the final iteration; the counter
    // reaches WIDTH on that same edge, which is also the DONE-entry edge.
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

    div_state_t           state_q;
    div_state_t           state_nxt;
    logic                 accept;
    logic                 last_iter;

    logic [CNT_BITS-1:0]  cnt_q;
    logic [WIDTH-1:0]     dvd_q;
    logic [WIDTH-1:0]     dsr_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;

    logic [WIDTH-1:0]     rem_step;
    logic                 q_bit;
    logic [WIDTH-1:0]     quo_step;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem_dat (rem_q),
        .dvd_msb (dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_nxt (rem_step),
        .q_bit   (q_bit)
    );

    assign quo_step = (quo_q << 1) | WIDTH'(q_bit);

    // State register; reset wins over any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode plus the handshake outputs derived from the current state.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        valid_out = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last_iter = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Single-cycle result strobe; valid_in is ignored here, so a held
                // request is picked up again only once IDLE has been re-entered.
                busy      = 1'b1;
                valid_out = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, iterate in BUSY, publish results on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            dvd_q <= dividend;
            dsr_q <= divisor;
            rem_q <= '0;
            quo_q <= '0;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + CNT_BITS'(1);
            dvd_q <= dvd_q << 1;
            rem_q <= rem_step;
            quo_q <= quo_step;
            if (last_iter) begin
                // Take the final bit straight from the step so results land with DONE.
                quotient  <= quo_step;
                remainder <= rem_step;
            end
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed self-checking bench for iterative_divider (WIDTH=64).
// Latency: checks the accept-to-valid_out distance of WIDTH edges.
// Backpressure: exercises held valid_in, mid-operation reset and operand churn.
module tb_iterative_divider;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         valid_in;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         valid_out;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    iterative_divider #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .valid_out (valid_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Pulse valid_in for one accept edge, then track the result strobe.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_q, input logic [63:0] exp_r, input bit scramble);
        int lat;
        int busy_cnt;
        dividend = a;
        divisor  = b;
        valid_in = 1'b1;
        @(posedge clk); #1;          // E0
        valid_in = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat      = -1;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            if (scramble) begin
                dividend = {$urandom, $urandom};
                divisor  = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (valid_out) lat = k;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'd64);
        check_eq({tag, "_q"}, quotient, exp_q);
        check_eq({tag, "_r"}, remainder, exp_r);
        check_eq({tag, "_busycyc"}, 64'(busy_cnt), 64'd65);
        @(posedge clk); #1;          // E65: back to IDLE
        check_eq({tag, "_vo_drop"}, 64'(valid_out), 64'd0);
        check_eq({tag, "_busy_drop"}, 64'(busy), 64'd0);
        check_eq({tag, "_q_hold"}, quotient, exp_q);
    endtask

    initial begin
        int pulses;
        int next_exp;

        rst      = 1'b1;
        valid_in = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_q", quotient, 64'd0);
        check_eq("rst_r", remainder, 64'd0);
        check_eq("rst_vo", 64'(valid_out), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);

        // Request present on the very first edge after reset release.
        rst = 1'b0;
        run_op("d100_7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0);

        run_op("div0", 64'h0123_4567_89AB_CDEF, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b0);
        run_op("max_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        run_op("d5_9", 64'd5, 64'd9, 64'd0, 64'd5, 1'b0);

        // valid_in held over edges E0..E199: accepts land every 66 edges
        // (E0, E66, E132, E198), so strobes appear at 64, 130, 196 and 262 only.
        dividend = 64'd50;
        divisor  = 64'd5;
        valid_in = 1'b1;
        pulses   = 0;
        next_exp = 64;
        for (int k = 0; k < 270; k++) begin
            @(posedge clk); #1;
            if (k == 199) valid_in = 1'b0;
            if (valid_out) begin
                pulses++;
                check_eq("hold_pos", 64'(k), 64'(next_exp));
                check_eq("hold_q", quotient, 64'd10);
                check_eq("hold_r", remainder, 64'd0);
                next_exp = k + 66;
            end
        end
        check_eq("hold_pulses", 64'(pulses), 64'd4);

        // Reset one cycle after iteration 30 aborts the operation.
        dividend = 64'd100;
        divisor  = 64'd7;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_q", quotient, 64'd0);
        check_eq("abort_r", remainder, 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk); #1;
            if (valid_out) pulses++;
        end
        check_eq("abort_pulses", 64'(pulses), 64'd0);
        check_eq("abort_idle", 64'(busy), 64'd0);
        run_op("d9_3", 64'd9, 64'd3, 64'd3, 64'd0, 1'b0);

        // Inputs churn every cycle after accept; result must reflect 1000/33.
        run_op("churn", 64'd1000, 64'd33, 64'd30, 64'd10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
